sd_lesepuffer: RTL and testbench

SD_LESEPUFFER -- requirements
Module: sd_lesepuffer

---
 rtl/sd_lesepuffer.sv | 136 +++++++++++++
 tb/tb_sd_lesepuffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sd_lesepuffer.sv
// rtl/sd_lesepuffer.sv - single-line read buffer in front of an SD word reader
module sd_lesepuffer #(
  parameter int ZEILENWORTE = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Adresse,
  input  logic        Lesen,
  input  logic        Invalidieren,
  output logic [31:0] Daten,
  output logic        Fertig,
  output logic        Busy,
  output logic [31:0] SD_Adresse,
  output logic        SD_Lesen,
  input  logic [31:0] SD_Daten,
  input  logic        SD_Fertig,
  input  logic        SD_Busy
);

  typedef enum logic [2:0] {IDLE, HIT, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [27:0] tag_q, tag_d;
  logic        valid_q, valid_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  k_q, k_d;
  logic        inv_q, inv_d;
  logic [31:0] daten_q, daten_d;
  logic        fertig_q, fertig_d;
  logic [31:0] sd_adr_q, sd_adr_d;
  logic        line_we;
  logic [31:0] line_q [ZEILENWORTE];

  assign Daten      = daten_q;
  assign Fertig     = fertig_q;
  assign SD_Adresse = sd_adr_q;
  assign SD_Lesen   = (state_q == REQ);
  assign Busy       = (state_q != IDLE);

  // Control and status registers; the line storage itself is left unreset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      k_q      <= '0;
      inv_q    <= 1'b0;
      daten_q  <= '0;
      fertig_q <= 1'b0;
      sd_adr_q <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      inv_q    <= inv_d;
      daten_q  <= daten_d;
      fertig_q <= fertig_d;
      sd_adr_q <= sd_adr_d;
    end
  end

  // Line fill: one word per completed SD read, written at the fill index.
  always_ff @(posedge Clock) begin
    if (!Reset && line_we) begin
      line_q[k_q] <= SD_Daten;
    end
  end

  // Next-state logic: hit lookup, 16-word fill handshake and result delivery.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    k_d      = k_q;
    inv_d    = inv_q;
    daten_d  = daten_q;
    fertig_d = 1'b0;
    sd_adr_d = sd_adr_q;
    line_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Lesen) begin
          idx_d = Adresse[3:0];
          if (valid_q && !Invalidieren && (tag_q == Adresse[31:4])) begin
            state_d = HIT;
          end else begin
            state_d  = REQ;
            k_d      = 4'd0;
            tag_d    = Adresse[31:4];
            valid_d  = 1'b0;
            inv_d    = 1'b0;
            sd_adr_d = {Adresse[31:4], 4'd0};
          end
        end else if (Invalidieren) begin
          valid_d = 1'b0;
        end
      end
      HIT: begin
        daten_d  = line_q[idx_q];
        fertig_d = 1'b1;
        state_d  = IDLE;
        if (Invalidieren) valid_d = 1'b0;
      end
      REQ: begin
        if (Invalidieren) inv_d = 1'b1;
        if (SD_Busy) state_d = WAIT;
      end
      WAIT: begin
        if (Invalidieren) inv_d = 1'b1;
        if (!SD_Busy && SD_Fertig) begin
          line_we = 1'b1;
          if (k_q == 4'd15) begin
            state_d = DONE;
          end else begin
            k_d      = k_q + 4'd1;
            sd_adr_d = {tag_q, k_q + 4'd1};
            state_d  = REQ;
          end
        end
      end
      DONE: begin
        // A pending or simultaneous invalidation keeps the fresh line unusable.
        valid_d  = !inv_q && !Invalidieren;
        daten_d  = line_q[idx_q];
        fertig_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_lesepuffer.sv
// tb/tb_sd_lesepuffer.sv - randomized self-checking bench for sd_lesepuffer
module tb_sd_lesepuffer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Adresse = '0;
  logic        Lesen = 1'b0;
  logic        Invalidieren = 1'b0;
  logic [31:0] Daten;
  logic        Fertig;
  logic        Busy;
  logic [31:0] SD_Adresse;
  logic        SD_Lesen;
  logic [31:0] SD_Daten = '0;
  logic        SD_Fertig = 1'b0;
  logic        SD_Busy = 1'b0;

  int checks = 0;
  int failures = 0;

  sd_lesepuffer dut (
    .Clock(Clock), .Reset(Reset), .Adresse(Adresse), .Lesen(Lesen),
    .Invalidieren(Invalidieren), .Daten(Daten), .Fertig(Fertig), .Busy(Busy),
    .SD_Adresse(SD_Adresse), .SD_Lesen(SD_Lesen), .SD_Daten(SD_Daten),
    .SD_Fertig(SD_Fertig), .SD_Busy(SD_Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // SD word reader model: accepts a request, stays busy a random time, returns 0xA000_0000+addr.
  logic [31:0] sd_log[$];
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;
  int          fertig_cnt = 0;
  int          dbl_cnt = 0;
  logic        prev_f = 1'b0;

  always @(negedge Clock) begin
    if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy = 1'b0; SD_Busy = 1'b0; SD_Fertig = 1'b1;
        SD_Daten = 32'hA000_0000 + m_addr;
      end else begin
        m_cnt--;
      end
    end else if (SD_Lesen) begin
      m_busy = 1'b1; SD_Busy = 1'b1; SD_Fertig = 1'b0;
      m_addr = SD_Adresse; m_cnt = $urandom_range(0, 3);
      sd_log.push_back(SD_Adresse);
    end
    if (Fertig) fertig_cnt++;
    if (Fertig && prev_f) dbl_cnt++;
    prev_f = Fertig;
  end

  // Reference: what the buffer should currently hold.
  logic        exp_valid = 1'b0;
  logic [27:0] exp_tag = '0;

  task automatic do_read(input logic [31:0] a, input logic inv, input int inv_at, input logic noise);
    logic        hit;
    int          n0, f0, cyc, nreq;
    logic [31:0] got;
    hit = exp_valid && !inv && (exp_tag == a[31:4]);
    n0 = sd_log.size();
    f0 = fertig_cnt;
    Adresse = a; Lesen = 1'b1; Invalidieren = inv;
    @(posedge Clock);
    cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
      Invalidieren = (cyc == inv_at) && !hit;
      Lesen = noise && Busy && ($urandom_range(0, 1) == 1);
    end while (!Fertig && cyc < 3000);
    Lesen = 1'b0; Invalidieren = 1'b0;
    got = Daten;
    check("read_timeout", {31'd0, cyc >= 3000}, 32'd0);
    check("read_daten", got, 32'hA000_0000 + a);
    if (hit) check("hit_latency", cyc, 32'd2);
    repeat (3) @(negedge Clock);
    #1;
    check("fertig_once", fertig_cnt - f0, 32'd1);
    nreq = sd_log.size() - n0;
    check("sd_req_count", nreq, hit ? 32'd0 : 32'd16);
    if (!hit && nreq == 16)
      for (int i = 0; i < 16; i++)
        check("sd_req_addr", sd_log[n0 + i], {a[31:4], 4'd0} + i);
    if (!hit) begin
      exp_tag = a[31:4];
      exp_valid = (inv_at == 0);
    end
  endtask

  initial begin
    int n0, t;
    logic [31:0] a;
    logic [27:0] lines [4];
    repeat (2) @(negedge Clock);
    check("rst_fertig", {31'd0, Fertig}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_sd_lesen", {31'd0, SD_Lesen}, 32'd0);
    check("rst_sd_adresse", SD_Adresse, 32'd0);
    check("rst_daten", Daten, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    do_read(32'h0000_0123, 1'b0, 0, 1'b0);   // cold miss
    do_read(32'h0000_012A, 1'b0, 0, 1'b0);   // hit
    do_read(32'h0000_0200, 1'b0, 0, 1'b0);   // line change
    do_read(32'h0000_0123, 1'b0, 0, 1'b0);   // misses again
    do_read(32'h0000_012F, 1'b0, 0, 1'b0);   // hit
    do_read(32'h0000_0121, 1'b1, 0, 1'b0);   // invalidate with read -> refill
    do_read(32'h0000_0122, 1'b0, 0, 1'b0);   // hit
    do_read(32'h0000_0300, 1'b0, 5, 1'b0);   // invalidate during fill
    do_read(32'h0000_0301, 1'b0, 0, 1'b0);   // must miss
    do_read(32'h0000_0302, 1'b0, 0, 1'b0);   // hit
    do_read(32'h0000_0400, 1'b0, 0, 1'b1);   // miss with Lesen noise while busy
    do_read(32'h0000_040C, 1'b0, 0, 1'b1);   // hit with noise

    // Invalidate alone in idle
    Invalidieren = 1'b1;
    @(negedge Clock);
    Invalidieren = 1'b0;
    exp_valid = 1'b0;
    do_read(32'h0000_0405, 1'b0, 0, 1'b0);

    // Reset in the middle of a fill at k=7
    n0 = sd_log.size();
    Adresse = 32'h0000_0500; Lesen = 1'b1;
    @(negedge Clock);
    Lesen = 1'b0;
    t = 0;
    while (sd_log.size() - n0 < 8 && t < 2000) begin @(negedge Clock); t++; end
    check("reach_k7_timeout", {31'd0, t >= 2000}, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_fertig", {31'd0, Fertig}, 32'd0);
    check("abort_sd_lesen", {31'd0, SD_Lesen}, 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_daten", Daten, 32'd0);
    check("abort_sd_adresse", SD_Adresse, 32'd0);
    Reset = 1'b0;
    exp_valid = 1'b0;
    t = 0;
    while (m_busy && t < 100) begin @(negedge Clock); t++; end
    repeat (3) @(negedge Clock);
    check("abort_no_fertig", {31'd0, Fertig}, 32'd0);
    do_read(32'h0000_0125, 1'b0, 0, 1'b0);

    // Randomized reads over a few lines
    lines[0] = 28'h12; lines[1] = 28'h20; lines[2] = 28'h13; lines[3] = 28'h0;
    for (int i = 0; i < 30; i++) begin
      lines[3] = 28'($urandom);
      a = {lines[$urandom_range(0, 3)], 4'($urandom)};
      do_read(a, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0) ? $urandom_range(1, 20) : 0,
              ($urandom_range(0, 1) == 1));
    end

    check("no_double_fertig", dbl_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
